if_fetch: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch_if_id_reg.sv | 27 ++
 rtl/if_fetch.sv | 132 +++++++++++++
 tb/tb_if_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, stall-vector indices, fetch FSM encoding and IF/ID payload for the fetch stage.
package if_fetch_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned STALL_W  = 6;
  localparam int unsigned STALL_IF = 1;
  localparam int unsigned STALL_ID = 2;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } if_id_t;

endpackage

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: loads a completed fetch, otherwise bubbles unless decode is held.
module if_id_reg import if_fetch_pkg::*; #(
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   hold_i,
  input  if_id_t data_i,
  output if_id_t data_o
);

  if_id_t data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '{pc: '0, inst: NOP_INST, adel: 1'b0};
    end else if (load_i) begin
      data_q <= data_i;
    end else if (!hold_i) begin
      data_q <= '{pc: '0, inst: NOP_INST, adel: 1'b0};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, ROM req/ack FSM, branch redirect and IF/ID register.
// Optional IF_MISALIGN_EN: misaligned PCs skip the ROM and deliver a NOP flagged on if_excp_adel_o.
module if_fetch import if_fetch_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic               rom_req_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic               rom_ack_i,
  input  logic [INST_W-1:0]  rom_data_i,
  output logic [ADDR_W-1:0]  id_pc_o,
  output logic [INST_W-1:0]  id_inst_o,
  output logic               stallreq_o,
  output logic               if_excp_adel_o
);

`ifdef IF_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, redirect_addr_q, redirect_addr_d, next_pc;
  logic              redirect_pending_q, redirect_pending_d;
  logic [INST_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              stall_if, stall_id, misaligned, fetch_ack, id_load, branch_take;
  logic              stall_unused;
  if_id_t            id_data, id_q;

  assign stall_if     = stall[STALL_IF];
  assign stall_id     = stall[STALL_ID];
  assign stall_unused = ^{stall[STALL_W-1:STALL_ID+1], stall[STALL_IF-1:0]};
  assign misaligned   = MISALIGN_EN && (pc_q[1:0] != 2'b00);
  assign fetch_ack    = (state_q == IF_FETCH) && !misaligned && rom_ack_i;
  assign branch_take  = branch_flag_i && !stall_id;
  assign next_pc      = redirect_pending_q ? redirect_addr_q : pc_q + ADDR_W'(4);

  // A fetch completes into IF/ID only when IF is not held.
  always_comb begin
    id_load = 1'b0;
    if (state_q == IF_FETCH && (misaligned || rom_ack_i) && !stall_if) id_load = 1'b1;
    if (state_q == IF_HOLD && hold_valid_q && !stall_if)                 id_load = 1'b1;
  end

  always_comb begin
    id_data.pc   = pc_q;
    id_data.inst = (state_q == IF_HOLD) ? hold_q : (misaligned ? NOP_INST : rom_data_i);
    id_data.adel = misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IF_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_IDLE:  state_d = IF_FETCH;
      IF_FETCH: if (fetch_ack && stall_if) state_d = IF_HOLD;
      IF_HOLD:  if (!stall_if) state_d = IF_FETCH;
      default:  state_d = IF_IDLE;
    endcase
  end

  always_comb begin
    rom_req_o  = 1'b0;
    rom_addr_o = MISALIGN_EN ? pc_q : {pc_q[ADDR_W-1:2], 2'b00};
    if (state_q == IF_FETCH && !misaligned) rom_req_o = 1'b1;
  end

  assign stallreq_o = rom_req_o && !rom_ack_i;

  // A branch seen on the cycle the delay slot completes redirects directly; otherwise it is parked.
  always_comb begin
    pc_d               = pc_q;
    redirect_pending_d = redirect_pending_q;
    redirect_addr_d    = redirect_addr_q;
    hold_d             = hold_q;
    hold_valid_d       = hold_valid_q;
    if (id_load) begin
      pc_d               = branch_take ? branch_target_address_i : next_pc;
      redirect_pending_d = 1'b0;
    end else if (branch_take) begin
      redirect_pending_d = 1'b1;
      redirect_addr_d    = branch_target_address_i;
    end
    if (fetch_ack && stall_if) begin
      hold_d       = rom_data_i;
      hold_valid_d = 1'b1;
    end else if (state_q == IF_HOLD && !stall_if) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      redirect_pending_q <= 1'b0;
      redirect_addr_q    <= '0;
      hold_q             <= '0;
      hold_valid_q       <= 1'b0;
    end else begin
      pc_q               <= pc_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_addr_q    <= redirect_addr_d;
      hold_q             <= hold_d;
      hold_valid_q       <= hold_valid_d;
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (id_load),
    .hold_i (stall_id),
    .data_i (id_data),
    .data_o (id_q)
  );

  assign id_pc_o        = id_q.pc;
  assign id_inst_o      = id_q.inst;
  assign if_excp_adel_o = id_q.adel & MISALIGN_EN;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: ROM model with per-address latency, ctrl stall model, inline checks.
// Define IF_MISALIGN_EN to also exercise the misaligned-fetch path.
module tb_if_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk, rst, branch_flag_i, rom_req_o, rom_ack_i, stallreq_o, if_excp_adel_o;
  logic [5:0]  stall, stall_force;
  logic [31:0] branch_target_address_i, rom_addr_o, rom_data_i, id_pc_o, id_inst_o;
  logic [31:0] slow_addr;
  logic        ack_force;
  int unsigned lat, wait_cnt;
  int          n_chk, n_fail;

  if_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom_req_o               (rom_req_o),
    .rom_addr_o              (rom_addr_o),
    .rom_ack_i               (rom_ack_i),
    .rom_data_i              (rom_data_i),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o),
    .stallreq_o              (stallreq_o),
    .if_excp_adel_o          (if_excp_adel_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb rom_ack_i  = ack_force || (rom_req_o && (rom_addr_o != slow_addr || wait_cnt >= lat));
  always_comb rom_data_i = inst_of(rom_addr_o);
  always_comb stall      = stall_force | (stallreq_o ? 6'b000011 : 6'b000000);
  always @(posedge clk) wait_cnt <= (rom_req_o && !rom_ack_i) ? wait_cnt + 1 : 0;

  task automatic do_reset();
    rst = 1'b1; stall_force = '0; branch_flag_i = 1'b0; branch_target_address_i = '0;
    ack_force = 1'b0; lat = 0; slow_addr = NONE;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (rom_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", rom_req_o); end
    n_chk++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", rom_addr_o); end
    n_chk++; if (id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_id_pc: got %h expected 0", id_pc_o); end
    n_chk++; if (id_inst_o !== NOP) begin n_fail++; $display("FAIL rst_id_inst: got %h expected %h", id_inst_o, NOP); end
    n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rst_stallreq: got %b expected 0", stallreq_o); end
    n_chk++; if (if_excp_adel_o !== 1'b0) begin n_fail++; $display("FAIL rst_adel: got %b expected 0", if_excp_adel_o); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    do_reset();
    @(negedge clk);
    n_chk++; if (rom_req_o !== 1'b1) begin n_fail++; $display("FAIL zw_req: got %b expected 1", rom_req_o); end
    n_chk++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL zw_addr: got %h expected 0", rom_addr_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = 32'(4 * i);
      n_chk++; if (id_pc_o !== e) begin n_fail++; $display("FAIL zw_pc[%0d]: got %h expected %h", i, id_pc_o, e); end
      n_chk++; if (id_inst_o !== inst_of(e)) begin n_fail++; $display("FAIL zw_inst[%0d]: got %h expected %h", i, id_inst_o, inst_of(e)); end
      n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL zw_stallreq[%0d]: got %b expected 0", i, stallreq_o); end
      n_chk++; if (if_excp_adel_o !== 1'b0) begin n_fail++; $display("FAIL zw_adel[%0d]: got %b expected 0", i, if_excp_adel_o); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    slow_addr = 32'h8; lat = 3;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (stallreq_o !== 1'b1) begin n_fail++; $display("FAIL ws_stallreq[%0d]: got %b expected 1", k, stallreq_o); end
      n_chk++; if (rom_addr_o !== 32'h8) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h expected 8", k, rom_addr_o); end
      if (k > 0) begin
        n_chk++; if (id_inst_o !== NOP) begin n_fail++; $display("FAIL ws_bubble_inst[%0d]: got %h expected %h", k, id_inst_o, NOP); end
        n_chk++; if (id_pc_o !== 32'h0) begin n_fail++; $display("FAIL ws_bubble_pc[%0d]: got %h expected 0", k, id_pc_o); end
      end
      @(negedge clk);
    end
    n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL ws_ack_stallreq: got %b expected 0", stallreq_o); end
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'h8) begin n_fail++; $display("FAIL ws_pc: got %h expected 8", id_pc_o); end
    n_chk++; if (id_inst_o !== inst_of(32'h8)) begin n_fail++; $display("FAIL ws_inst: got %h expected %h", id_inst_o, inst_of(32'h8)); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (6) @(negedge clk);
    n_chk++; if (rom_addr_o !== 32'h14) begin n_fail++; $display("FAIL br_slot_addr: got %h expected 14", rom_addr_o); end
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    @(negedge clk);
    branch_flag_i = 1'b0;
    n_chk++; if (id_pc_o !== 32'h14) begin n_fail++; $display("FAIL br_slot_pc: got %h expected 14", id_pc_o); end
    n_chk++; if (rom_addr_o !== 32'h100) begin n_fail++; $display("FAIL br_tgt_addr: got %h expected 100", rom_addr_o); end
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'h100) begin n_fail++; $display("FAIL br_tgt_pc: got %h expected 100", id_pc_o); end
    n_chk++; if (id_inst_o !== inst_of(32'h100)) begin n_fail++; $display("FAIL br_tgt_inst: got %h expected %h", id_inst_o, inst_of(32'h100)); end
    // same branch, but the delay-slot fetch acks two cycles late
    do_reset();
    slow_addr = 32'h14; lat = 2;
    repeat (6) @(negedge clk);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    @(negedge clk);
    branch_flag_i = 1'b0;
    n_chk++; if (stallreq_o !== 1'b1) begin n_fail++; $display("FAIL brl_wait: got %b expected 1", stallreq_o); end
    repeat (2) @(negedge clk);
    n_chk++; if (id_pc_o !== 32'h14) begin n_fail++; $display("FAIL brl_slot_pc: got %h expected 14", id_pc_o); end
    n_chk++; if (rom_addr_o !== 32'h100) begin n_fail++; $display("FAIL brl_tgt_addr: got %h expected 100", rom_addr_o); end
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'h100) begin n_fail++; $display("FAIL brl_tgt_pc: got %h expected 100", id_pc_o); end
  endtask

  task automatic test_hold();
    do_reset();
    repeat (3) @(negedge clk);
    stall_force = 6'b000110;
    @(negedge clk);
    n_chk++; if (rom_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b expected 0", rom_req_o); end
    n_chk++; if (id_pc_o !== 32'h4) begin n_fail++; $display("FAIL hold_frozen_pc: got %h expected 4", id_pc_o); end
    n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL hold_stallreq: got %b expected 0", stallreq_o); end
    @(negedge clk);
    n_chk++; if (id_inst_o !== inst_of(32'h4)) begin n_fail++; $display("FAIL hold_frozen_inst: got %h expected %h", id_inst_o, inst_of(32'h4)); end
    stall_force = '0;
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'h8) begin n_fail++; $display("FAIL hold_rel_pc: got %h expected 8", id_pc_o); end
    n_chk++; if (id_inst_o !== inst_of(32'h8)) begin n_fail++; $display("FAIL hold_rel_inst: got %h expected %h", id_inst_o, inst_of(32'h8)); end
    n_chk++; if (rom_addr_o !== 32'hC) begin n_fail++; $display("FAIL hold_next_addr: got %h expected c", rom_addr_o); end
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'hC) begin n_fail++; $display("FAIL hold_next_pc: got %h expected c", id_pc_o); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    slow_addr = 32'h8; lat = 5;
    repeat (4) @(negedge clk);
    n_chk++; if (stallreq_o !== 1'b1) begin n_fail++; $display("FAIL rmf_waiting: got %b expected 1", stallreq_o); end
    rst = 1'b1;
    @(negedge clk);
    ack_force = 1'b1;
    #1;
    n_chk++; if (rom_req_o !== 1'b0) begin n_fail++; $display("FAIL rmf_req: got %b expected 0", rom_req_o); end
    n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL rmf_stallreq: got %b expected 0", stallreq_o); end
    n_chk++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL rmf_addr: got %h expected 0", rom_addr_o); end
    n_chk++; if (id_pc_o !== 32'h0) begin n_fail++; $display("FAIL rmf_id_pc: got %h expected 0", id_pc_o); end
    n_chk++; if (id_inst_o !== NOP) begin n_fail++; $display("FAIL rmf_id_inst: got %h expected %h", id_inst_o, NOP); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (id_inst_o !== NOP) begin n_fail++; $display("FAIL rmf_late_ack: got %h expected %h", id_inst_o, NOP); end
    ack_force = 1'b0; slow_addr = NONE; lat = 0;
    #1;
    n_chk++; if (rom_req_o !== 1'b1) begin n_fail++; $display("FAIL rmf_refetch_req: got %b expected 1", rom_req_o); end
    n_chk++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL rmf_refetch_addr: got %h expected 0", rom_addr_o); end
    @(negedge clk);
    n_chk++; if (id_inst_o !== inst_of(32'h0)) begin n_fail++; $display("FAIL rmf_first_inst: got %h expected %h", id_inst_o, inst_of(32'h0)); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag_i = 1'b0;
    n_chk++; if (rom_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h expected fffffffc", rom_addr_o); end
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_pc: got %h expected fffffffc", id_pc_o); end
    n_chk++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h expected 0", rom_addr_o); end
    @(negedge clk);
    n_chk++; if (id_inst_o !== inst_of(32'h0)) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", id_inst_o, inst_of(32'h0)); end
  endtask

`ifdef IF_MISALIGN_EN
  task automatic test_misalign();
    do_reset();
    @(negedge clk);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
    @(negedge clk);
    branch_flag_i = 1'b0;
    n_chk++; if (rom_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %b expected 0", rom_req_o); end
    n_chk++; if (stallreq_o !== 1'b0) begin n_fail++; $display("FAIL mis_stallreq: got %b expected 0", stallreq_o); end
    @(negedge clk);
    n_chk++; if (id_pc_o !== 32'h102) begin n_fail++; $display("FAIL mis_pc: got %h expected 102", id_pc_o); end
    n_chk++; if (id_inst_o !== NOP) begin n_fail++; $display("FAIL mis_inst: got %h expected %h", id_inst_o, NOP); end
    n_chk++; if (if_excp_adel_o !== 1'b1) begin n_fail++; $display("FAIL mis_adel: got %b expected 1", if_excp_adel_o); end
    n_chk++; if (rom_addr_o !== 32'h106) begin n_fail++; $display("FAIL mis_next_addr: got %h expected 106", rom_addr_o); end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; stall_force = '0; branch_flag_i = 1'b0; branch_target_address_i = '0;
    ack_force = 1'b0; lat = 0; slow_addr = NONE;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_hold();
    test_reset_mid_fetch();
    test_wrap();
`ifdef IF_MISALIGN_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
